// File: rtl/am_sample_fifo.sv
// Purpose: first-word-fall-through sample buffer feeding the AM PWM modulator, with
//          fill level, almost-full back-pressure and sticky overflow/underflow flags.
// Latency: 1 clock write-to-read; head word on `sample` combinationally while !empty.
// Backpressure: writes while full are dropped (sets overflow); reads while empty ignored (sets underflow).
//
// Ports: clk, rst (async active-low), clear (sync flush), din/write (source side),
//        sample/empty/read (modulator side), full, almost_full, level, overflow, underflow.
module am_sample_fifo #(
    parameter int ADDR_WIDTH        = 4,
    parameter int DATA_WIDTH        = 8,
    parameter int ALMOST_FULL_LEVEL = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  write,
    output logic                  full,
    output logic                  almost_full,
    output logic [DATA_WIDTH-1:0] sample,
    output logic                  empty,
    input  logic                  read,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic wr_en;
    logic rd_en;

    // Flags decode straight from the registered pointers; MSB is the wrap bit.
    always_comb begin
        empty       = (wr_ptr_q == rd_ptr_q);
        full        = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                      (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);
        level       = wr_ptr_q - rd_ptr_q;
        almost_full = (level >= (ADDR_WIDTH+1)'(ALMOST_FULL_LEVEL));
        sample      = empty ? '0 : mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
        overflow    = overflow_q;
        underflow   = underflow_q;
    end

    // Clear swallows any strobe in its cycle, so nothing is accepted and no flag is set.
    always_comb begin
        wr_en       = write && !full && !clear;
        rd_en       = read && !empty && !clear;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clear) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
            // Flag decisions use the pre-edge full/empty: a same-cycle read never
            // makes room for a write, and a same-cycle write never feeds a read.
            if (write && full)  overflow_d  = 1'b1;
            if (read  && empty) underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is not reset; stale words are hidden because empty forces sample to 0.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= din;
    end

endmodule

// File: tb/tb_am_sample_fifo.sv
module tb_am_sample_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clear = 1'b0;
    logic [7:0] din = '0;
    logic       write = 1'b0;
    logic       read = 1'b0;
    logic       full, almost_full, empty, overflow, underflow;
    logic [7:0] sample;
    logic [4:0] level;

    int n_cmp = 0;
    int n_fail = 0;

    // Scoreboard of words the FIFO should hold, plus model sticky flags.
    logic [7:0] sb[$];
    logic       m_ovf = 1'b0;
    logic       m_udf = 1'b0;
    logic       rd_fire;
    logic [7:0] rd_got, rd_exp;

    always #5 clk = ~clk;

    am_sample_fifo #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .ALMOST_FULL_LEVEL(12)) dut (
        .clk(clk), .rst(rst), .clear(clear), .din(din), .write(write),
        .full(full), .almost_full(almost_full), .sample(sample), .empty(empty),
        .read(read), .level(level), .overflow(overflow), .underflow(underflow)
    );

    // One clock of stimulus. Expected words are pushed when a write should be accepted
    // and popped when a read should be accepted; the head word seen by the modulator
    // before the edge is captured in rd_got for the calling test to compare.
    task automatic drive(input logic w, input logic [7:0] d, input logic r, input logic clr);
        bit m_full, m_empty;
        write = w; din = d; read = r; clear = clr;
        rd_fire = 1'b0;
        #1;
        if (clr) begin
            sb.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            m_full  = (sb.size() == 16);
            m_empty = (sb.size() == 0);
            if (r && !m_empty) begin
                rd_fire = 1'b1;
                rd_got  = sample;
                rd_exp  = sb.pop_front();
            end
            if (r && m_empty) m_udf = 1'b1;
            if (w && !m_full) sb.push_back(d);
            if (w && m_full)  m_ovf = 1'b1;
        end
        @(posedge clk); #1;
        write = 1'b0; read = 1'b0; clear = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        sb.delete(); m_ovf = 1'b0; m_udf = 1'b0;
        n_cmp++; if (empty !== 1'b1)     begin n_fail++; $display("FAIL reset_empty got %b want 1", empty); end
        n_cmp++; if (full !== 1'b0)      begin n_fail++; $display("FAIL reset_full got %b want 0", full); end
        n_cmp++; if (level !== 5'd0)     begin n_fail++; $display("FAIL reset_level got %0d want 0", level); end
        n_cmp++; if (sample !== 8'h00)   begin n_fail++; $display("FAIL reset_sample got %h want 00", sample); end
        n_cmp++; if ({overflow, underflow} !== 2'b00)
            begin n_fail++; $display("FAIL reset_flags got %b%b want 00", overflow, underflow); end
    endtask

    task automatic test_single_word();
        drive(1'b1, 8'hA5, 1'b0, 1'b0);
        n_cmp++; if (empty !== 1'b0)   begin n_fail++; $display("FAIL single_empty got %b want 0", empty); end
        n_cmp++; if (sample !== 8'hA5) begin n_fail++; $display("FAIL single_sample got %h want a5", sample); end
        n_cmp++; if (level !== 5'd1)   begin n_fail++; $display("FAIL single_level got %0d want 1", level); end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        n_cmp++; if (!rd_fire || rd_got !== rd_exp)
            begin n_fail++; $display("FAIL single_pop got %h want %h", rd_got, rd_exp); end
        n_cmp++; if (empty !== 1'b1 || sample !== 8'h00)
            begin n_fail++; $display("FAIL single_drained empty=%b sample=%h want 1/00", empty, sample); end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 8'(i), 1'b0, 1'b0);
            n_cmp++; if (almost_full !== (i >= 11) || full !== (i >= 15))
                begin n_fail++; $display("FAIL fill_flags write %0d af=%b full=%b want %b/%b",
                                         i + 1, almost_full, full, i >= 11, i >= 15); end
            n_cmp++; if (int'(level) !== sb.size())
                begin n_fail++; $display("FAIL fill_level got %0d want %0d", level, sb.size()); end
        end
        n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL fill_overflow got %b want 1", overflow); end
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            n_cmp++; if (!rd_fire || rd_got !== 8'(i))
                begin n_fail++; $display("FAIL drain_data got %h want %h", rd_got, 8'(i)); end
        end
        n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty got %b want 1", empty); end
        drive(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 5; i++) drive(1'b1, 8'h50 + 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 8'h60 + 8'(i), 1'b1, 1'b0);
            n_cmp++; if (!rd_fire || rd_got !== rd_exp)
                begin n_fail++; $display("FAIL b2b_order got %h want %h", rd_got, rd_exp); end
            n_cmp++; if (level !== 5'd5) begin n_fail++; $display("FAIL b2b_level got %0d want 5", level); end
        end
        while (sb.size() < 16) drive(1'b1, 8'hC0 + 8'(sb.size()), 1'b0, 1'b0);
        drive(1'b1, 8'hEE, 1'b1, 1'b0);
        n_cmp++; if (!rd_fire || rd_got !== rd_exp)
            begin n_fail++; $display("FAIL full_rw_pop got %h want %h", rd_got, rd_exp); end
        n_cmp++; if (overflow !== 1'b1 || level !== 5'd15)
            begin n_fail++; $display("FAIL full_rw ovf=%b level=%0d want 1/15", overflow, level); end
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        drive(1'b1, 8'h3C, 1'b1, 1'b0);
        n_cmp++; if (underflow !== 1'b1 || level !== 5'd1 || sample !== 8'h3C)
            begin n_fail++; $display("FAIL empty_rw udf=%b level=%0d sample=%h want 1/1/3c",
                                     underflow, level, sample); end
        drive(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    // Emulated modulator pulls whenever the FIFO is non-empty, at random cadence.
    task automatic test_wrap_stream();
        int sent = 0, got = 0, cyc = 0;
        bit w, r;
        while (got < 40 && cyc < 2000) begin
            w = (sent < 40) && ($urandom_range(0, 3) != 0);
            r = (sb.size() != 0) && ($urandom_range(0, 2) != 0);
            drive(w, 8'(sent), r, 1'b0);
            if (w) sent++;
            if (rd_fire) begin
                n_cmp++; if (rd_got !== 8'(got))
                    begin n_fail++; $display("FAIL stream_data got %h want %h", rd_got, 8'(got)); end
                got++;
            end
            cyc++;
        end
        n_cmp++; if (got != 40) begin n_fail++; $display("FAIL stream_timeout got %0d words want 40", got); end
        n_cmp++; if ({overflow, underflow, empty} !== {m_ovf, m_udf, 1'b1})
            begin n_fail++; $display("FAIL stream_flags got %b%b%b want 001", overflow, underflow, empty); end
    endtask

    task automatic test_clear_reset();
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) drive(1'b1, 8'h70 + 8'(i), 1'b0, 1'b0);
        n_cmp++; if (level !== 5'd7 || underflow !== 1'b1)
            begin n_fail++; $display("FAIL preclear level=%0d udf=%b want 7/1", level, underflow); end
        drive(1'b1, 8'hEE, 1'b0, 1'b1);
        n_cmp++; if (level !== 5'd0 || empty !== 1'b1 || {overflow, underflow} !== 2'b00)
            begin n_fail++; $display("FAIL clear level=%0d empty=%b flags=%b%b want 0/1/00",
                                     level, empty, overflow, underflow); end
        for (int i = 0; i < 3; i++) drive(1'b1, 8'h90 + 8'(i), 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        n_cmp++; if ({empty, full, almost_full, level, sample, overflow, underflow} !== {1'b1, 17'b0})
            begin n_fail++; $display("FAIL async_reset e=%b f=%b af=%b lvl=%0d s=%h o=%b u=%b want reset values",
                                     empty, full, almost_full, level, sample, overflow, underflow); end
        sb.delete(); m_ovf = 1'b0; m_udf = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        drive(1'b1, 8'h77, 1'b0, 1'b0);
        n_cmp++; if (level !== 5'd1 || sample !== 8'h77 || dut.wr_ptr_q !== 5'd1)
            begin n_fail++; $display("FAIL post_reset_write level=%0d sample=%h want 1/77", level, sample); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_fill_overflow();
        test_back_to_back();
        test_wrap_stream();
        test_clear_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/am_sample_fifo.md
# am_sample_fifo

Single-clock, first-word-fall-through sample buffer that sits directly upstream of the AM PWM modulator. It accepts 8-bit amplitude samples from the host/source side and presents them on the modulator's FIFO interface (`sample`, `empty`, `read`). The modulator latches `sample` in the same cycle it asserts `read`, so the head word is always valid while `empty` is low. The block adds fill-level reporting, almost-full back-pressure and sticky overflow/underflow flags for debug.

## Interface
Parameters:
- `ADDR_WIDTH`, 4: log2 of depth; depth = 2^ADDR_WIDTH = 16 entries.
- `DATA_WIDTH`, 8: sample width; must match the modulator's 8-bit `sample`.
- `ALMOST_FULL_LEVEL`, 12: `almost_full` is high when level >= this value.

Ports:
- `clk` in 1: single system clock; all logic on rising edge.
- `rst` in 1: reset, asynchronous assert, active-low. Synchronous release is handled upstream.
- `clear` in 1: synchronous flush; empties the FIFO and clears both sticky flags.
- `din` in DATA_WIDTH: write data.
- `write` in 1: write strobe, one word per cycle while high.
- `full` out 1: level == depth.
- `almost_full` out 1: level >= ALMOST_FULL_LEVEL.
- `sample` out DATA_WIDTH: head word, FWFT; forced to 0 while `empty`.
- `empty` out 1: level == 0.
- `read` in 1: pop strobe from the modulator, one word per cycle while high.
- `level` out ADDR_WIDTH+1: current occupancy, 0..depth.
- `overflow` out 1: sticky; a write was attempted while full.
- `underflow` out 1: sticky; a read was attempted while empty.

## Operation
- Storage: 2^ADDR_WIDTH x DATA_WIDTH register array. Write and read pointers are ADDR_WIDTH+1 bits; the MSB is the wrap bit.
- `level` = wr_ptr − rd_ptr, modulo 2^(ADDR_WIDTH+1). `empty` = (pointers equal). `full` = (addresses equal, wrap bits differ). All flags are decoded combinationally from the registered pointers.
- Write accepted iff `write` && !`full`:
  - mem[wr_ptr addr] <= `din`
  - wr_ptr increments and wraps naturally.
- Write while `full` is dropped, even if `read` is high in the same cycle, and sets `overflow`.
- Read accepted iff `read` && !`empty`: rd_ptr increments.
- Read while `empty` is ignored, even if `write` is high in the same cycle, and sets `underflow`. The concurrent write is still accepted.
- Simultaneous accepted read and write: both pointers advance and `level` is unchanged.
- `sample` = mem[rd_ptr addr] when !`empty`, else 0. No registered output stage.
- `clear` (sync, highest priority after `rst`):
  - both pointers <= 0, `overflow` <= 0, `underflow` <= 0.
  - Any `write`/`read` in that cycle is discarded and sets no flag.
- Reset values (`rst` low): pointers 0, `empty`=1, `full`=0, `almost_full`=0, `level`=0, `sample`=0, `overflow`=0, `underflow`=0. Memory contents are not reset.
- Reset mid-operation: all state returns to reset values immediately (asynchronous) and buffered data is discarded. The first write after `rst` rises lands at address 0.
- No state machine beyond the pointer/flag registers. Sequential state = pointers, two sticky flags, memory.

## Timing
- Write-to-read latency: 1 clock. A word written at edge N makes `empty` low and `sample` valid after edge N.
- The modulator may sample `sample` combinationally in any cycle where `empty`=0. A `read` high at edge M exposes the next word (or `empty`=1) after edge M.
- `full`, `almost_full` and `level` update after the edge that accepts the causing write or read.
- `overflow`/`underflow` assert after the offending edge and hold until `clear` or `rst`.
- Throughput: one write and one read per clock, sustained.

## Test plan
- Reset: hold `rst`=0 for 3 cycles, then release -> `empty`=1, `full`=0, `level`=0, `sample`=0, both flags 0.
- Single word: write 0xA5 at edge 1 -> after edge 1 `empty`=0, `sample`=0xA5, `level`=1. Then `read` at edge 2 -> `empty`=1, `sample`=0.
- Fill and overflow: write 0x00..0x10 on 17 consecutive cycles -> `almost_full` rises after the 12th write, `full` after the 16th. The 17th word is dropped and `overflow`=1. Drain 16 reads -> data 0x00..0x0F in order.
- Simultaneous read/write: at `level`=5, assert `write`+`read` for 10 cycles -> `level` stays 5 and the output order is preserved. Same at `level`=16 -> write dropped, `overflow`=1, `level`=15. Same at `level`=0 -> `underflow`=1, `level`=1.
- Wrap-around with modulator: stream 40 ramp samples (0..39) into a connected AM modulator -> pointers wrap twice, modulator consumes 0..39 in order, no flags set.
- Clear and async reset: at `level`=7 pulse `clear` with `write` high -> `level`=0 and flags cleared. Refill to 3, drop `rst` mid-cycle -> all outputs reach reset values before the next edge.
